// File: rtl/fpu_issue.sv
// fpu_issue: buffers core FPU commands in a 2-entry queue, issues them one at a
// time to the FPU with a ready/valid style handshake, waits for the result (with
// a cycle timeout) and returns data, condition flag and error to the core.
module fpu_issue #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  // command from core
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [OP_WIDTH-1:0]       req_op,
  input  logic [REG_ADDR_WIDTH-1:0] req_x1,
  input  logic [REG_ADDR_WIDTH-1:0] req_x2,
  input  logic [REG_ADDR_WIDTH-1:0] req_y,
  input  logic [31:0]               req_data,
  // FPU side
  output logic [OP_WIDTH-1:0]       fpu_operation,
  output logic [REG_ADDR_WIDTH-1:0] fpu_x1,
  output logic [REG_ADDR_WIDTH-1:0] fpu_x2,
  output logic [REG_ADDR_WIDTH-1:0] fpu_y,
  output logic [31:0]               fpu_in_data,
  output logic                      fpu_ready,
  input  logic                      fpu_valid,
  input  logic [31:0]               fpu_out_data,
  input  logic                      fpu_cond,
  // response to core
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic                      rsp_cond,
  output logic                      rsp_err,
  output logic                      err_sticky
);

  localparam int CMD_W = OP_WIDTH + 3 * REG_ADDR_WIDTH + 32;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    COND  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Command queue (2 entries, no bypass)
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] fifo_mem [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] cmd_in;
  logic [CMD_W-1:0] head_cmd;

  state_t state_reg, state_next;

  assign fifo_full  = (count_reg == 2'd2);
  assign fifo_empty = (count_reg == 2'd0);
  // Ready is held low during reset so nothing is pushed into a queue being cleared.
  assign req_ready  = ~fifo_full & ~rst;
  assign push       = req_valid & req_ready;
  assign pop        = (state_reg == IDLE) & ~fifo_empty;
  assign cmd_in     = {req_op, req_x1, req_x2, req_y, req_data};
  assign head_cmd   = fifo_mem[rd_ptr_reg];

  // Queue storage: written on accepted command; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= cmd_in;
    end
  end

  // Queue pointers and occupancy; push+pop together leave occupancy unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM and its registered outputs
  // ---------------------------------------------------------------------------
  logic [OP_WIDTH-1:0]       op_reg, op_next;
  logic [REG_ADDR_WIDTH-1:0] x1_reg, x1_next;
  logic [REG_ADDR_WIDTH-1:0] x2_reg, x2_next;
  logic [REG_ADDR_WIDTH-1:0] y_reg, y_next;
  logic [31:0]               in_data_reg, in_data_next;
  logic                      fpu_ready_reg, fpu_ready_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic                      rsp_valid_reg, rsp_valid_next;
  logic [31:0]               rsp_data_reg, rsp_data_next;
  logic                      rsp_cond_reg, rsp_cond_next;
  logic                      rsp_err_reg, rsp_err_next;
  logic                      sticky_reg, sticky_next;

  // State and output registers; reset clears everything including queued work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      x1_reg        <= '0;
      x2_reg        <= '0;
      y_reg         <= '0;
      in_data_reg   <= '0;
      fpu_ready_reg <= 1'b0;
      cnt_reg       <= 8'd0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      rsp_cond_reg  <= 1'b0;
      rsp_err_reg   <= 1'b0;
      sticky_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      x1_reg        <= x1_next;
      x2_reg        <= x2_next;
      y_reg         <= y_next;
      in_data_reg   <= in_data_next;
      fpu_ready_reg <= fpu_ready_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_cond_reg  <= rsp_cond_next;
      rsp_err_reg   <= rsp_err_next;
      sticky_reg    <= sticky_next;
    end
  end

  // Next-state logic: issue head, wait for result or timeout, collect cond, respond
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    x1_next        = x1_reg;
    x2_next        = x2_reg;
    y_next         = y_reg;
    in_data_next   = in_data_reg;
    fpu_ready_next = fpu_ready_reg;
    cnt_next       = cnt_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_cond_next  = rsp_cond_reg;
    rsp_err_next   = rsp_err_reg;
    sticky_next    = sticky_reg;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          op_next        = head_cmd[CMD_W-1 -: OP_WIDTH];
          x1_next        = head_cmd[32 + 3*REG_ADDR_WIDTH - 1 -: REG_ADDR_WIDTH];
          x2_next        = head_cmd[32 + 2*REG_ADDR_WIDTH - 1 -: REG_ADDR_WIDTH];
          y_next         = head_cmd[32 + REG_ADDR_WIDTH - 1 -: REG_ADDR_WIDTH];
          in_data_next   = head_cmd[31:0];
          fpu_ready_next = 1'b1;
          cnt_next       = 8'd0;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (fpu_valid) begin
          rsp_data_next  = fpu_out_data;
          fpu_ready_next = 1'b0;
          state_next     = COND;
        end else if (cnt_reg == TIMEOUT_LIM - 8'd1) begin
          cnt_next       = cnt_reg + 8'd1;
          fpu_ready_next = 1'b0;
          rsp_data_next  = 32'd0;
          rsp_cond_next  = 1'b0;
          rsp_err_next   = 1'b1;
          sticky_next    = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      COND: begin
        // The FPU condition register lags its result by one edge.
        rsp_cond_next  = fpu_cond;
        rsp_err_next   = 1'b0;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fpu_operation = op_reg;
  assign fpu_x1        = x1_reg;
  assign fpu_x2        = x2_reg;
  assign fpu_y         = y_reg;
  assign fpu_in_data   = in_data_reg;
  assign fpu_ready     = fpu_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_data      = rsp_data_reg;
  assign rsp_cond      = rsp_cond_reg;
  assign rsp_err       = rsp_err_reg;
  assign err_sticky    = sticky_reg;

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed bench for fpu_issue with a small behavioural FPU model.
module tb_fpu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_x1, req_x2, req_y;
  logic [31:0] req_data;
  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1, fpu_x2, fpu_y;
  logic [31:0] fpu_in_data;
  logic        fpu_ready, fpu_valid, fpu_cond;
  logic [31:0] fpu_out_data;
  logic        rsp_valid, rsp_ready, rsp_cond, rsp_err, err_sticky;
  logic [31:0] rsp_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fpu_issue #(.REG_ADDR_WIDTH(5), .OP_WIDTH(6), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_y(req_y), .req_data(req_data),
    .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
    .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
    .fpu_out_data(fpu_out_data), .fpu_cond(fpu_cond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cond(rsp_cond), .rsp_err(rsp_err), .err_sticky(err_sticky)
  );

  // ---------------- FPU model ----------------
  // Registered mode: valid pulses m_delay edges after fpu_ready is seen high,
  // result = fixed value or in_data+1. Comb mode: valid = fpu_ready (zero delay).
  // The condition flag updates on the edge after valid.
  int          m_delay = 3;
  bit          m_never = 1'b0;
  bit          m_comb  = 1'b0;
  bit          m_fixed = 1'b0;
  bit          m_cond  = 1'b0;
  logic [31:0] m_res   = 32'd0;
  logic        fpu_valid_q = 1'b0;
  logic        fpu_cond_q  = 1'b0;
  logic [31:0] out_q       = 32'd0;
  int          m_cnt  = 0;
  bit          m_done = 1'b0;

  assign fpu_valid    = m_comb ? fpu_ready : fpu_valid_q;
  assign fpu_out_data = m_comb ? fpu_in_data + 32'd1 : out_q;
  assign fpu_cond     = fpu_cond_q;

  always @(posedge clk) begin
    fpu_valid_q <= 1'b0;
    if (fpu_valid) fpu_cond_q <= m_cond;
    if (!fpu_ready) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (!m_done && !m_comb) begin
      m_cnt <= m_cnt + 1;
      if (!m_never && (m_cnt + 1 >= m_delay)) begin
        fpu_valid_q <= 1'b1;
        out_q       <= m_fixed ? m_res : fpu_in_data + 32'd1;
        m_done      <= 1'b1;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [33:0] rsp_q[$];
  int          rises = 0;
  int          stab_viol = 0;
  logic        prev_rdy = 1'b0;
  logic [52:0] prev_ops = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every completed response handshake, in order
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_cond, rsp_data});
  end

  // fpu_ready rising edges and operand stability while fpu_ready stays high
  always @(negedge clk) begin
    if (fpu_ready && !prev_rdy) rises <= rises + 1;
    if (fpu_ready && prev_rdy &&
        ({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data} !== prev_ops))
      stab_viol <= stab_viol + 1;
    prev_rdy <= fpu_ready;
    prev_ops <= {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data};
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic push(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [31:0] d);
    int w;
    w = 0;
    req_valid = 1'b1; req_op = op; req_x1 = a; req_x2 = b; req_y = c; req_data = d;
    while (!req_ready && w < 200) begin
      tick(1);
      w++;
    end
    chk("push_accept", 32'(w < 200), 32'd1);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] ed, input logic ec, input logic ee);
    int w;
    logic [33:0] r;
    w = 0;
    while (rsp_q.size() == 0 && w < 300) begin
      tick(1);
      w++;
    end
    chk({tag, "_seen"}, 32'(rsp_q.size() > 0), 32'd1);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      $display("rsp %s: data=%h cond=%0d err=%0d", tag, r[31:0], r[32], r[33]);
      chk({tag, "_data"}, r[31:0], ed);
      chk({tag, "_cond"}, 32'(r[32]), 32'(ec));
      chk({tag, "_err"},  32'(r[33]), 32'(ee));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w, acc4, rel, r0;
    req_valid = 1'b0; req_op = '0; req_x1 = '0; req_x2 = '0; req_y = '0; req_data = '0;
    rsp_ready = 1'b1;
    acc4 = 0; rel = 0;

    // Reset state
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fpu_ready", 32'(fpu_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sticky",    32'(err_sticky), 32'd0);
    chk("rst_x1",        32'(fpu_x1), 32'd0);
    tick(2);
    rst = 1'b0;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);

    // Single op: valid 3 cycles after fpu_ready, lands on the last cycle before timeout
    m_fixed = 1'b1; m_res = 32'h4040_0000; m_delay = 3;
    push(6'h00, 5'd1, 5'd2, 5'd3, 32'h0);
    chk("t1_ready_at_accept", 32'(fpu_ready), 32'd0);
    tick(1);
    chk("t1_ready_next", 32'(fpu_ready), 32'd1);
    chk("t1_op", 32'(fpu_operation), 32'h00);
    chk("t1_x1", 32'(fpu_x1), 32'd1);
    chk("t1_x2", 32'(fpu_x2), 32'd2);
    chk("t1_y",  32'(fpu_y),  32'd3);
    w = 0;
    while (!fpu_valid && w < 20) begin
      tick(1);
      w++;
    end
    chk("t1_valid_delay", 32'(w), 32'd3);
    tick(1);
    chk("t1_cond_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_cond_fpu_ready", 32'(fpu_ready), 32'd0);
    tick(1);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data",  rsp_data, 32'h4040_0000);
    chk("t1_rsp_err",   32'(rsp_err), 32'd0);
    get_rsp("t1", 32'h4040_0000, 1'b0, 1'b0);
    m_fixed = 1'b0;

    // Cond path: flag set one edge after valid, then cleared for the next op
    m_delay = 2; m_cond = 1'b1;
    push(6'h05, 5'd4, 5'd5, 5'd6, 32'h100);
    get_rsp("t2a", 32'h101, 1'b1, 1'b0);
    m_cond = 1'b0;
    push(6'h05, 5'd7, 5'd8, 5'd9, 32'h200);
    get_rsp("t2b", 32'h201, 1'b0, 1'b0);

    // Back-pressure: first command goes straight to the FSM, next two fill the queue
    rsp_ready = 1'b0; m_delay = 1;
    push(6'h01, 5'd1, 5'd1, 5'd1, 32'd10);
    push(6'h01, 5'd2, 5'd2, 5'd2, 32'd20);
    chk("t3_ready_one_queued", 32'(req_ready), 32'd1);
    push(6'h01, 5'd3, 5'd3, 5'd3, 32'd30);
    chk("t3_ready_full", 32'(req_ready), 32'd0);
    fork
      begin
        push(6'h01, 5'd4, 5'd4, 5'd4, 32'd40);
        acc4 = cyc;
      end
      begin
        tick(10);
        chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
        chk("t3_hold_data",  rsp_data, 32'd11);
        rsp_ready = 1'b1;
        rel = cyc;
      end
    join
    chk("t3_4th_after_pop", 32'(acc4 > rel), 32'd1);
    get_rsp("t3a", 32'd11, 1'b0, 1'b0);
    get_rsp("t3b", 32'd21, 1'b0, 1'b0);
    get_rsp("t3c", 32'd31, 1'b0, 1'b0);
    get_rsp("t3d", 32'd41, 1'b0, 1'b0);

    // Timeout: FPU never answers, TIMEOUT=4
    m_never = 1'b1;
    push(6'h02, 5'd3, 5'd3, 5'd3, 32'd50);
    tick(1);
    w = 0;
    while (fpu_ready && w < 50) begin
      tick(1);
      w++;
    end
    chk("t4_issue_cycles", 32'(w), 32'd4);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_sticky", 32'(err_sticky), 32'd1);
    get_rsp("t4", 32'd0, 1'b0, 1'b1);
    m_never = 1'b0; m_delay = 1;
    push(6'h00, 5'd1, 5'd1, 5'd1, 32'd60);
    get_rsp("t4_good", 32'd61, 1'b0, 1'b0);
    chk("t4_sticky_persist", 32'(err_sticky), 32'd1);

    // Zero-delay FPU: ready must drop between ops
    m_comb = 1'b1;
    r0 = rises;
    push(6'h03, 5'd1, 5'd2, 5'd3, 32'd70);
    push(6'h03, 5'd4, 5'd5, 5'd6, 32'd80);
    push(6'h03, 5'd7, 5'd8, 5'd9, 32'd90);
    get_rsp("t5a", 32'd71, 1'b0, 1'b0);
    get_rsp("t5b", 32'd81, 1'b0, 1'b0);
    get_rsp("t5c", 32'd91, 1'b0, 1'b0);
    chk("t5_ready_pulses", 32'(rises - r0), 32'd3);
    chk("t5_operand_stable", 32'(stab_viol), 32'd0);
    m_comb = 1'b0;

    // Reset mid-operation with one command queued
    m_never = 1'b1;
    push(6'h04, 5'd5, 5'd6, 5'd7, 32'd100);
    push(6'h04, 5'd8, 5'd9, 5'd10, 32'd110);
    chk("t6_pre_ready", 32'(fpu_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_fpu_ready", 32'(fpu_ready), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_x1_clr",    32'(fpu_x1), 32'd0);
    chk("t6_sticky_clr", 32'(err_sticky), 32'd0);
    tick(2);
    m_never = 1'b0; m_delay = 1;
    r0 = rises;
    rst = 1'b0;
    #1;
    chk("t6_rel_req_ready", 32'(req_ready), 32'd1);
    tick(20);
    chk("t6_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("t6_no_issue", 32'(rises - r0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
